// File: rtl/cic_pkg.sv
// Shared types for the CIC decimator, its gain-normalisation bank and the rate sequencer.
package cic_pkg;

    localparam int unsigned RATE_W = 8;

    typedef logic [RATE_W-1:0] cic_rate_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        CLEAR  = 2'd2,
        SETTLE = 2'd3
    } cic_ctrl_state_t;

    // Phase value on which a period of `r` input samples completes.
    function automatic cic_rate_t rate_last(input cic_rate_t r);
        return r - cic_rate_t'(1);
    endfunction

endpackage

// File: rtl/cic_rate_ctrl_if.sv
// Rate-change request channel: valid/ready handshake plus a rejection pulse.
interface cic_rate_ctrl_if;
    import cic_pkg::*;

    cic_rate_t cfg_rate;
    logic      cfg_valid;
    logic      cfg_ready;
    logic      cfg_err;

    modport master (output cfg_rate, output cfg_valid, input cfg_ready, input cfg_err);
    modport slave  (input cfg_rate, input cfg_valid, output cfg_ready, output cfg_err);

endinterface

// File: rtl/cic_dec_counter.sv
// Phase counter and decimation strobe; `clear` zeroes the phase and drops that cycle's sample.
module cic_dec_counter
    import cic_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_valid,
    input  cic_rate_t rate,
    input  logic      clear,
    output logic      dec_stb,
    output logic      wrap_c
);

    cic_rate_t ph_q, ph_d;
    logic      stb_q;

    always_comb begin
        wrap_c = in_valid && !clear && (ph_q == rate_last(rate));
        ph_d   = ph_q;
        if (clear) begin
            ph_d = '0;
        end else if (in_valid) begin
            ph_d = wrap_c ? '0 : ph_q + cic_rate_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= '0;
            stb_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            stb_q <= wrap_c;
        end
    end

    assign dec_stb = stb_q;

endmodule

// File: rtl/cic_rate_ctrl.sv
// CIC rate sequencer: applies rate changes, clears the CIC and blanks output while combs refill.
// Build macro CIC_RATE_CTRL_SYNC_EN: defined -> rate change waits for the period boundary;
// undefined -> the partial period is abandoned after a single PEND cycle.
module cic_rate_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned CIC_ORDER    = 3,
    parameter cic_rate_t   DEFAULT_RATE = 8'd64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    cic_rate_ctrl_if.slave    cfg,
    output cic_rate_t         rate_o,
    output logic              dec_stb,
    output logic              cic_clear,
    output logic              out_en,
    output logic              busy
);

    localparam int unsigned SET_W = (CIC_ORDER < 2) ? 1 : $clog2(CIC_ORDER + 1);

    cic_ctrl_state_t state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    cic_rate_t        rate_q, rate_d;
    cic_rate_t        pend_q, pend_d;
    logic             clear_q, clear_d;
    logic             err_q, err_d;
    logic             out_en_q, out_en_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             hs_c;
    logic             wrap_c;
    logic             cnt_clr_c;
    logic             stb;

    assign hs_c      = cfg.cfg_valid && ready_q;
    assign cnt_clr_c = (state_q == CLEAR);

    cic_dec_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .rate     (rate_q),
        .clear    (cnt_clr_c),
        .dec_stb  (stb),
        .wrap_c   (wrap_c)
    );

    // Next state; every output is a registered function of the state being entered.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        rate_d   = rate_q;
        pend_d   = pend_q;
        err_d    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (hs_c) begin
                    if (cfg.cfg_rate == '0) begin
                        err_d = 1'b1;
                    end else if (cfg.cfg_rate != rate_q) begin
                        pend_d  = cfg.cfg_rate;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
`ifdef CIC_RATE_CTRL_SYNC_EN
                if (wrap_c) state_d = CLEAR;
`else
                state_d = CLEAR;
`endif
            end
            CLEAR: begin
                state_d  = SETTLE;
                settle_d = SET_W'(CIC_ORDER);
            end
            SETTLE: begin
                // Count blanked strobes as they appear so out_en rises the cycle after the last one.
                if (stb) begin
                    settle_d = settle_q - SET_W'(1);
                    if (settle_q == SET_W'(1)) state_d = RUN;
                end
            end
            default: state_d = SETTLE;
        endcase
        if (state_d == CLEAR) rate_d = pend_q;
        clear_d  = (state_d == CLEAR);
        out_en_d = (state_d == RUN) || (state_d == PEND);
        ready_d  = (state_d == RUN);
        busy_d   = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SETTLE;
            settle_q <= SET_W'(CIC_ORDER);
            rate_q   <= DEFAULT_RATE;
            pend_q   <= '0;
            clear_q  <= 1'b0;
            err_q    <= 1'b0;
            out_en_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            rate_q   <= rate_d;
            pend_q   <= pend_d;
            clear_q  <= clear_d;
            err_q    <= err_d;
            out_en_q <= out_en_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign rate_o        = rate_q;
    assign dec_stb       = stb;
    assign cic_clear     = clear_q;
    assign out_en        = out_en_q;
    assign busy          = busy_q;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Bench for cic_rate_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a sample-counting reference model.
module tb_cic_rate_ctrl;

    localparam int ORDER = 3;
    localparam int DEF   = 64;
`ifdef CIC_RATE_CTRL_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] rate_o;
    logic       dec_stb, cic_clear, out_en, busy;

    cic_rate_ctrl_if cfg_if ();

    cic_rate_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .cfg       (cfg_if),
        .rate_o    (rate_o),
        .dec_stb   (dec_stb),
        .cic_clear (cic_clear),
        .out_en    (out_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts samples per period, tracks the pending rate and blanked strobes left.
    int m_rate, m_ph, m_pend, m_blank;
    bit m_in_clear;
    bit w, run_now, pend_now, go, nrun, npend;
    bit e_stb, e_clr, e_err, e_ready, e_oen, e_busy;
    int e_rate;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rate = DEF; m_ph = 0; m_pend = -1; m_blank = ORDER; m_in_clear = 1'b0;
            e_stb = 0; e_clr = 0; e_err = 0; e_ready = 0; e_oen = 0; e_busy = 1; e_rate = DEF;
        end else begin
            run_now  = !m_in_clear && m_pend < 0 && m_blank == 0;
            pend_now = !m_in_clear && m_pend >= 0;
            w        = in_valid && !m_in_clear && (m_ph == m_rate - 1);
            go       = 1'b0;
            e_err    = 1'b0;
            if (run_now && cfg_if.cfg_valid) begin
                if (int'(cfg_if.cfg_rate) == 0) e_err = 1'b1;
                else if (int'(cfg_if.cfg_rate) != m_rate) m_pend = int'(cfg_if.cfg_rate);
            end else if (pend_now) begin
                go = SYNC ? w : 1'b1;
            end
            if (m_blank > 0 && e_stb) m_blank--;
            if (m_in_clear) begin m_blank = ORDER; m_pend = -1; end
            if (m_in_clear) m_ph = 0;
            else if (in_valid) m_ph = w ? 0 : m_ph + 1;
            if (go) m_rate = m_pend;
            m_in_clear = go;
            nrun    = !m_in_clear && m_pend < 0 && m_blank == 0;
            npend   = !m_in_clear && m_pend >= 0;
            e_stb   = w;
            e_clr   = go;
            e_rate  = m_rate;
            e_ready = nrun;
            e_oen   = nrun || npend;
            e_busy  = !nrun;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rate_o",    int'(rate_o),           e_rate);
            chk("dec_stb",   int'(dec_stb),          int'(e_stb));
            chk("cic_clear", int'(cic_clear),        int'(e_clr));
            chk("cfg_err",   int'(cfg_if.cfg_err),   int'(e_err));
            chk("cfg_ready", int'(cfg_if.cfg_ready), int'(e_ready));
            chk("out_en",    int'(out_en),           int'(e_oen));
            chk("busy",      int'(busy),             int'(e_busy));
        end
    end

    task automatic tick(input bit iv, input bit cv, input logic [7:0] cr, output bit hs);
        in_valid         = iv;
        cfg_if.cfg_valid = cv;
        cfg_if.cfg_rate  = cr;
        hs = cv && cfg_if.cfg_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit iv);
        bit h;
        tick(iv, 1'b0, 8'd0, h);
    endtask

    task automatic request(input logic [7:0] r, input string name);
        bit h = 1'b0;
        for (int i = 0; i < 600 && !h; i++) tick(1'b1, 1'b1, r, h);
        chk(name, int'(h), 1);
    endtask

    int t[3];
    int nstb, k, ncl;
    bit hs;
    bit pat[6];

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_rate  = 8'd0;
        repeat (3) step(1'b0);
        cmp_en = 1'b1;
        chk("rst_rate", int'(rate_o), 64);
        chk("rst_oen", int'(out_en), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ready", int'(cfg_if.cfg_ready), 0);
        chk("rst_stb", int'(dec_stb), 0);
        rst_n = 1'b1;

        // Default rate out of reset: three blanked strobes 64 samples apart.
        nstb = 0;
        for (int i = 0; i < 400 && nstb < 3; i++) begin
            step(1'b1);
            if (dec_stb) begin
                t[nstb] = i;
                nstb++;
                chk("boot_blank", int'(out_en), 0);
            end
        end
        chk("boot_nstb", nstb, 3);
        chk("boot_first", t[0], 63);
        chk("boot_period", t[1] - t[0], 64);
        step(1'b1);
        chk("boot_oen", int'(out_en), 1);
        chk("boot_ready", int'(cfg_if.cfg_ready), 1);

        // Rate change to 8 requested at phase 20.
        repeat (19) step(1'b1);
        tick(1'b1, 1'b1, 8'd8, hs);
        chk("hs8", int'(hs), 1);
        k = 0;
        for (int i = 1; i <= 300 && k == 0; i++) begin
            step(1'b1);
            if (cic_clear) k = i;
        end
        chk("clr_delay", k, SYNC ? 43 : 1);
        chk("clr_old_stb", int'(dec_stb), SYNC ? 1 : 0);
        chk("clr_rate", int'(rate_o), 8);
        chk("clr_oen", int'(out_en), 0);
        nstb = 0;
        for (int i = 1; i <= 100 && nstb < 3; i++) begin
            step(1'b1);
            if (dec_stb) begin
                t[nstb] = i;
                nstb++;
                chk("r8_blank", int'(out_en), 0);
            end
        end
        chk("r8_first", t[0], 9);
        chk("r8_period", t[2] - t[1], 8);
        step(1'b1);
        chk("r8_oen", int'(out_en), 1);

        // Rate 0 is rejected.
        tick(1'b1, 1'b1, 8'd0, hs);
        chk("hs0", int'(hs), 1);
        chk("err_pulse", int'(cfg_if.cfg_err), 1);
        chk("err_rate", int'(rate_o), 8);
        chk("err_noclr", int'(cic_clear), 0);
        step(1'b1);
        chk("err_one", int'(cfg_if.cfg_err), 0);

        // Rate 1: strobe follows every sample one cycle later.
        request(8'd1, "hs1");
        for (int i = 0; i < 100 && busy; i++) step(1'b1);
        chk("r1_run", int'(busy), 0);
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(pat[i]);
            chk("r1_stb", int'(dec_stb), int'(pat[i]));
        end

        // Same-rate request is a no-op.
        tick(1'b1, 1'b1, 8'd1, hs);
        chk("noop_hs", int'(hs), 1);
        chk("noop_ready", int'(cfg_if.cfg_ready), 1);
        chk("noop_clr", int'(cic_clear), 0);
        chk("noop_oen", int'(out_en), 1);

        // Reset during SETTLE discards the new rate.
        request(8'd16, "hs16");
        k = 0;
        for (int i = 0; i < 50 && k == 0; i++) begin
            step(1'b1);
            if (cic_clear) k = 1;
        end
        chk("r16_clr", k, 1);
        chk("r16_rate", int'(rate_o), 16);
        step(1'b1);
        step(1'b1);
        chk("r16_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rate", int'(rate_o), 64);
        chk("rst_mid_oen", int'(out_en), 0);
        step(1'b0);
        rst_n = 1'b1;
        ncl = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1);
            if (cic_clear) ncl++;
        end
        chk("post_rst_noclr", ncl, 0);
        chk("post_rst_rate", int'(rate_o), 64);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 5000; i++) begin
            logic [7:0] r;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) r = 8'd0;
            else if (sel == 1) r = rate_o;
            else if (sel < 6) r = 8'($urandom_range(1, 6));
            else r = 8'($urandom_range(1, 40));
            if ($urandom_range(0, 1999) == 0) rst_n = 1'b0;
            tick($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 8, r, hs);
            rst_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
